// File: rtl/apb_fabric_pkg.sv
// Shared definitions for the APB fabric: FSM state codes, slave index field width, clog2 helper.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package apb_fabric_pkg;

   // Width of the slave index field taken from PADDR
   localparam int IDX_W = 4;

   // Fabric FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ACCESS = 2'b01;
   localparam logic [1:0] ST_DECERR = 2'b10;
   localparam logic [1:0] ST_TMO    = 2'b11;

   // Ceiling log2, never less than 1 so a counter always has at least one bit
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/apb_tmo_counter.sv
// Watchdog wait-state counter: clear, count-enable, terminal count at TIMEOUT-1, saturates at TIMEOUT.
// Latency: terminal-count flag is a registered-count compare, valid the cycle after the count reaches it.
// Backpressure: none; counts only when enabled by the caller.
module apb_tmo_counter
   import apb_fabric_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam int               CNT_W   = clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment until the saturation value
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != SAT_VAL)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/apb_slave_mux_tmo.sv
// APB fabric stage: decodes PADDR to a slave, fans out PSEL, muxes responses, adds decode-error and stalled-slave watchdog.
// Latency: setup-phase PSELx is combinational from PADDR; responses are combinational muxes; no bubble between transfers.
// Backpressure: slave PREADY passes straight upstream; a slave stalled for TIMEOUT enable cycles is aborted with PSLVERR.
module apb_slave_mux_tmo
   import apb_fabric_pkg::*;
#(
   parameter int ADDRWIDTH     = 16,
   parameter int DATAWIDTH     = 32,
   parameter int NUM_SLAVES    = 4,
   parameter int SLV_ADDR_BITS = 12,
   parameter int TIMEOUT       = 255
)
(
   input  logic                             HCLK,
   input  logic                             HRESETn,
   input  logic                             PCLKEN,
   input  logic                             PSEL,
   input  logic                             PENABLE,
   input  logic [ADDRWIDTH-1:0]             PADDR,
   input  logic                             PWRITE,
   input  logic [DATAWIDTH-1:0]             PWDATA,
   output logic                             PREADY,
   output logic [DATAWIDTH-1:0]             PRDATA,
   output logic                             PSLVERR,
   output logic [NUM_SLAVES-1:0]            PSELx,
   input  logic [NUM_SLAVES-1:0]            PREADYx,
   input  logic [NUM_SLAVES-1:0]            PSLVERRx,
   input  logic [NUM_SLAVES*DATAWIDTH-1:0]  PRDATAx,
   output logic                             TMO_IRQ,
   output logic [ADDRWIDTH-1:0]             TMO_ADDR
);

   logic [1:0]           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 tmo_irq_q, tmo_irq_d;
   logic [ADDRWIDTH-1:0] tmo_addr_q, tmo_addr_d;

   logic [IDX_W-1:0]     idx;
   logic                 hit;
   logic                 setup;
   logic                 sel_rdy;
   logic                 sel_err;
   logic [DATAWIDTH-1:0] sel_dat;
   logic                 cnt_en;
   logic                 cnt_clr;
   logic                 cnt_tc;

   // Write direction and data are broadcast to the slaves outside this block
   logic unused_wr;
   assign unused_wr = ^{PWRITE, PWDATA};

   assign idx   = PADDR[SLV_ADDR_BITS +: IDX_W];
   assign hit   = (32'(idx) < NUM_SLAVES);
   assign setup = PSEL && !PENABLE;

   // Select the response of the slave captured at setup
   always_comb begin
      sel_rdy = 1'b0;
      sel_err = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_rdy = PREADYx[i];
            sel_err = PSLVERRx[i];
            sel_dat = PRDATAx[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   // Next-state logic; nothing advances without PCLKEN
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_en     = 1'b0;
      cnt_clr    = 1'b0;
      tmo_irq_d  = 1'b0;
      tmo_addr_d = tmo_addr_q;
      if (PCLKEN) begin
         case (state_q)
            ST_IDLE: begin
               if (setup) begin
                  if (hit) begin
                     state_d = ST_ACCESS;
                     idx_d   = idx;
                     cnt_clr = 1'b1;
                  end else begin
                     state_d = ST_DECERR;
                  end
               end
            end
            ST_ACCESS: begin
               if (!PSEL) begin
                  // Upstream dropped the transfer: abandon it silently
                  state_d = ST_IDLE;
               end else if (PENABLE) begin
                  if (sel_rdy) begin
                     // Ready takes priority over the watchdog on the same cycle
                     state_d = ST_IDLE;
                  end else if (cnt_tc) begin
                     state_d    = ST_TMO;
                     tmo_irq_d  = 1'b1;
                     tmo_addr_d = PADDR;
                  end else begin
                     cnt_en = 1'b1;
                  end
               end
            end
            ST_DECERR: begin
               if (PENABLE || !PSEL) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, captured index and watchdog report registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         tmo_irq_q  <= 1'b0;
         tmo_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tmo_irq_q  <= tmo_irq_d;
         tmo_addr_q <= tmo_addr_d;
      end
   end

   // Upstream response and per-slave select for the current state
   always_comb begin
      PREADY  = 1'b1;
      PSLVERR = 1'b0;
      PRDATA  = '0;
      PSELx   = '0;
      case (state_q)
         ST_IDLE: begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               if (idx == IDX_W'(i)) PSELx[i] = setup && hit;
            end
         end
         ST_ACCESS: begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               if (idx_q == IDX_W'(i)) PSELx[i] = PSEL;
            end
            PREADY  = sel_rdy;
            PSLVERR = sel_rdy && sel_err;
            PRDATA  = sel_dat;
         end
         ST_DECERR: begin
            PSLVERR = PENABLE;
         end
         default: begin
            PSLVERR = 1'b1;
         end
      endcase
   end

   apb_tmo_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo_cnt (
      .clk_i   (HCLK),
      .rst_n_i (HRESETn),
      .en_i    (cnt_en),
      .clr_i   (cnt_clr),
      .tc_o    (cnt_tc)
   );

   assign TMO_IRQ  = tmo_irq_q;
   assign TMO_ADDR = tmo_addr_q;

endmodule

// File: tb/tb_apb_slave_mux_tmo.sv
// Bench for apb_slave_mux_tmo: randomized APB transfers against a transfer-level reference model with a scoreboard.
// Latency: n/a.
// Backpressure: bench slaves insert a chosen number of wait states per transfer.
module tb_apb_slave_mux_tmo;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int NS  = 4;
   localparam int SAB = 12;
   localparam int TMO = 8;

   logic             HCLK = 1'b0;
   logic             HRESETn = 1'b0;
   logic             PCLKEN = 1'b1;
   logic             PSEL = 1'b0;
   logic             PENABLE = 1'b0;
   logic [AW-1:0]    PADDR = '0;
   logic             PWRITE = 1'b0;
   logic [DW-1:0]    PWDATA = '0;
   logic             PREADY;
   logic [DW-1:0]    PRDATA;
   logic             PSLVERR;
   logic [NS-1:0]    PSELx;
   logic [NS-1:0]    PREADYx = '0;
   logic [NS-1:0]    PSLVERRx = '0;
   logic [NS*DW-1:0] PRDATAx = '0;
   logic             TMO_IRQ;
   logic [AW-1:0]    TMO_ADDR;

   apb_slave_mux_tmo #(
      .ADDRWIDTH(AW), .DATAWIDTH(DW), .NUM_SLAVES(NS), .SLV_ADDR_BITS(SAB), .TIMEOUT(TMO)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(PSEL), .PENABLE(PENABLE),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
      .PSLVERR(PSLVERR), .PSELx(PSELx), .PREADYx(PREADYx), .PSLVERRx(PSLVERRx),
      .PRDATAx(PRDATAx), .TMO_IRQ(TMO_IRQ), .TMO_ADDR(TMO_ADDR)
   );

   initial forever #5 HCLK = ~HCLK;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            waits;
      int            irqs;
      logic          tmo;
      logic [AW-1:0] addr;
      logic [NS-1:0] psel;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err = 0;
   bit   clken_rand = 1'b0;
   int   m_waits = 0;
   int   m_irqs = 0;

   // Slave the address refers to, as a one-hot select (zero when unmapped)
   function automatic logic [NS-1:0] sel_of(input logic [AW-1:0] a);
      int i;
      i = int'(a[SAB +: 4]);
      return (i < NS) ? NS'(1 << i) : '0;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // APB clock enable: steady high, or random when toggling is requested
   initial forever begin
      @(posedge HCLK);
      #2;
      PCLKEN = clken_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Advance one PCLKEN-qualified APB cycle; reports PREADY seen in that cycle
   task automatic apb_tick(output logic rdy);
      logic en;
      int   n;
      en = 1'b0;
      rdy = 1'b0;
      n = 0;
      while (!en && n < 200) begin
         @(negedge HCLK);
         en  = PCLKEN;
         rdy = PREADY;
         @(posedge HCLK);
         #1;
         n++;
      end
      if (!en) begin
         n_err++;
         n_checks++;
         $display("FAIL pclken_stuck: no enabled cycle in %0d clocks", n);
      end
   endtask

   // One APB transfer; the slave holds PREADY low for 'waits' enable cycles
   task automatic xfer(input logic [AW-1:0] addr, input logic wr, input int waits,
                       input logic err, input logic [DW-1:0] data, input int gap);
      exp_t e;
      int   idx;
      int   k;
      logic rdy;
      idx    = int'(addr[SAB +: 4]);
      e.addr = addr;
      e.irqs = 0;
      e.tmo  = 1'b0;
      if (idx >= NS) begin
         e.rdata = '0; e.err = 1'b1; e.waits = 0; e.psel = '0;
      end else if (waits >= TMO) begin
         e.rdata = '0; e.err = 1'b1; e.waits = TMO; e.irqs = 1; e.tmo = 1'b1; e.psel = '0;
      end else begin
         e.rdata = data; e.err = err; e.waits = waits; e.psel = sel_of(addr);
      end
      exp_q.push_back(e);
      PRDATAx  = {$urandom(), $urandom(), $urandom(), $urandom()};
      PREADYx  = NS'($urandom());
      PSLVERRx = NS'($urandom());
      if (idx < NS) begin
         PRDATAx[idx*DW +: DW] = data;
         PSLVERRx[idx] = err;
         PREADYx[idx]  = 1'b0;
      end
      PADDR   = addr;
      PWRITE  = wr;
      PWDATA  = $urandom();
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      apb_tick(rdy);
      PENABLE = 1'b1;
      k = 0;
      rdy = 1'b0;
      while (!rdy && k < 4 * TMO + 40) begin
         if (idx < NS) PREADYx[idx] = (k >= waits);
         apb_tick(rdy);
         k++;
      end
      check("xfer_complete", {31'b0, rdy}, 32'd1);
      if (gap > 0) begin
         PSEL = 1'b0;
         PENABLE = 1'b0;
         PREADYx = '0;
         repeat (gap) begin
            @(posedge HCLK);
            #1;
         end
      end
   endtask

   // Monitor: checks setup decode, wait-state selects and every completed response
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         m_waits = 0;
         m_irqs = 0;
      end else begin
         if (PCLKEN && PSEL && !PENABLE) begin
            m_waits = 0;
            m_irqs = 0;
            check("setup_psel", 32'(PSELx), 32'(sel_of(PADDR)));
         end
         if (TMO_IRQ) m_irqs++;
         if (PCLKEN && PSEL && PENABLE) begin
            if (!PREADY) begin
               m_waits++;
               check("wait_psel", 32'(PSELx), 32'(sel_of(PADDR)));
            end else if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_completion: addr %h with no transfer pending", PADDR);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("prdata", PRDATA, e.rdata);
               check("pslverr", 32'(PSLVERR), 32'(e.err));
               check("wait_states", 32'(m_waits), 32'(e.waits));
               check("irq_pulses", 32'(m_irqs), 32'(e.irqs));
               check("done_psel", 32'(PSELx), 32'(e.psel));
               if (e.tmo) check("tmo_addr", 32'(TMO_ADDR), 32'(e.addr));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL sim_watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rdy;
      logic [3:0] ridx;
      // Reset values
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check("rst_psel", 32'(PSELx), 32'd0);
      check("rst_pready", 32'(PREADY), 32'd1);
      check("rst_pslverr", 32'(PSLVERR), 32'd0);
      check("rst_prdata", PRDATA, 32'd0);
      check("rst_irq", 32'(TMO_IRQ), 32'd0);
      check("rst_tmo_addr", 32'(TMO_ADDR), 32'd0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      // Directed cases
      xfer(16'h1004, 1'b1, 0, 1'b0, 32'h1111_2222, 1);
      xfer(16'h2000, 1'b0, 3, 1'b0, 32'hCAFE_0123, 0);
      xfer(16'h5000, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, 1);
      xfer(16'h3ABC, 1'b0, 100, 1'b0, 32'h0000_0000, 1);
      xfer(16'h3010, 1'b0, TMO - 1, 1'b1, 32'h5555_AAAA, 0);
      xfer(16'h0123, 1'b1, 0, 1'b1, 32'h7777_8888, 0);
      clken_rand = 1'b1;
      xfer(16'h2000, 1'b0, 3, 1'b0, 32'hCAFE_0123, 1);
      xfer(16'h3FFC, 1'b0, 100, 1'b0, 32'h0000_0000, 1);
      clken_rand = 1'b0;
      repeat (2) begin
         @(posedge HCLK);
         #1;
      end

      // Reset in the middle of a stalled access
      PRDATAx = '0;
      PREADYx = '0;
      PADDR   = 16'h3F00;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      apb_tick(rdy);
      PENABLE = 1'b1;
      repeat (4) apb_tick(rdy);
      HRESETn = 1'b0;
      @(negedge HCLK);
      check("midrst_psel", 32'(PSELx), 32'd0);
      check("midrst_pready", 32'(PREADY), 32'd1);
      check("midrst_tmo_addr", 32'(TMO_ADDR), 32'd0);
      check("midrst_irq", 32'(TMO_IRQ), 32'd0);
      @(posedge HCLK);
      #1;
      PSEL = 1'b0;
      PENABLE = 1'b0;
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;
      xfer(16'h0040, 1'b0, 1, 1'b0, 32'h0BAD_F00D, 1);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         ridx = 4'($urandom_range(0, 5));
         clken_rand = ($urandom_range(0, 3) == 0);
         xfer({ridx, 12'($urandom())}, 1'($urandom()), $urandom_range(0, 10),
              1'($urandom()), $urandom(), $urandom_range(0, 2));
      end
      clken_rand = 1'b0;
      PSEL = 1'b0;
      PENABLE = 1'b0;
      repeat (5) @(posedge HCLK);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
